// File: rtl/usb_tx_serializer_pkg.sv
// Shared types and constants for the USB full-speed transmit serializer:
// FSM state encoding, PID select codes and their on-wire PID bytes.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    PID  = 3'd2,
    DATA = 3'd3,
    EOP  = 3'd4
  } tx_state_t;

  typedef logic [2:0] pid_sel_t;

  localparam pid_sel_t PID_SEL_DATA0 = 3'd0;
  localparam pid_sel_t PID_SEL_DATA1 = 3'd1;
  localparam pid_sel_t PID_SEL_ACK   = 3'd2;
  localparam pid_sel_t PID_SEL_NAK   = 3'd3;
  localparam pid_sel_t PID_SEL_STALL = 3'd4;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [1:0] EOP_SE0_BITS = 2'd2;

  // Reserved select codes fall back to STALL.
  function automatic logic [7:0] pid_byte(input pid_sel_t sel);
    case (sel)
      PID_SEL_DATA0: return PID_DATA0;
      PID_SEL_DATA1: return PID_DATA1;
      PID_SEL_ACK:   return PID_ACK;
      PID_SEL_NAK:   return PID_NAK;
      default:       return PID_STALL;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_serializer_if.sv
// Packet request and payload stream between the TX packet controller
// (master) and the serializer (slave).
interface usb_tx_serializer_if
  import usb_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
);
  logic              tx_start;
  pid_sel_t          tx_pid_sel;
  logic              tx_has_data;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (
    output tx_start, tx_pid_sel, tx_has_data, in_data, in_valid, in_last,
    input  in_ready
  );

  modport slave (
    input  tx_start, tx_pid_sel, tx_has_data, in_data, in_valid, in_last,
    output in_ready
  );
endinterface

// File: rtl/usb_tx_serializer_nrzi_enc.sv
// NRZI line encoder: a 0 toggles the line, a 1 holds it; SE0 overrides the
// line without disturbing the encoder state, and the J bit re-arms it to J.
module usb_nrzi_enc (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic sync_start,
  input  logic se0,
  input  logic j_force,
  input  logic data_bit,
  output logic line
);
  logic lvl_q;
  logic base;
  logic nxt;

  always_comb begin
    base = sync_start ? 1'b1 : lvl_q;
    nxt  = data_bit ? base : ~base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b1;
      line  <= 1'b1;
    end else if (strobe) begin
      if (se0) begin
        line <= 1'b0;
      end else if (j_force) begin
        lvl_q <= 1'b1;
        line  <= 1'b1;
      end else begin
        lvl_q <= nxt;
        line  <= nxt;
      end
    end
  end
endmodule

// File: rtl/usb_tx_serializer.sv
// USB full-speed TX serializer: SYNC, PID, optional payload, EOP with bit
// stuffing and bit pacing. Define USB_TX_NRZI_EN for an NRZI-encoded line.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_PERIOD = 1,
  parameter int unsigned SHIFT_MSB  = 0
) (
  input  logic                clk,
  input  logic                rst,
  usb_tx_serializer_if.slave  bus,
  output logic                serial_out,
  output logic                bit_strobe,
  output logic                eop,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam int unsigned TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned LW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);

  tx_state_t         st_q, st_n;
  logic [TW-1:0]     timer_q, timer_n;
  logic [DATA_W-1:0] sh_q, sh_n;
  logic [LW-1:0]     left_q, left_n;
  logic [2:0]        ones_q, ones_n;
  logic [1:0]        eop_cnt_q, eop_cnt_n;
  logic              last_q, last_n;
  logic              has_data_q, has_data_n;
  pid_sel_t          sel_q, sel_n;

  logic line_q, line_n;
  logic eop_q, eop_n;
  logic strobe_q, strobe_n;
  logic busy_q;
  logic done_q, done_n;
  logic under_q, under_n;
  logic ready_q, ready_n;

  logic              accept;
  logic              sync_start;
  logic              j_bit;
  logic              do_load;
  logic              do_shift;
  logic              go_eop;
  logic [DATA_W-1:0] ld;
  logic [LW-1:0]     ld_len;
  logic [2:0]        ones_base;

  function automatic logic [DATA_W-1:0] place_byte(input logic [7:0] b);
    logic [DATA_W-1:0] v;
    v = '0;
    if (SHIFT_MSB != 0) v[DATA_W-1 -: 8] = b;
    else                v[7:0] = b;
    return v;
  endfunction

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return (SHIFT_MSB != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v);
    return (SHIFT_MSB != 0) ? (v << 1) : (v >> 1);
  endfunction

  always_comb begin
    st_n       = st_q;
    timer_n    = timer_q;
    sh_n       = sh_q;
    left_n     = left_q;
    ones_n     = ones_q;
    eop_cnt_n  = eop_cnt_q;
    last_n     = last_q;
    has_data_n = has_data_q;
    sel_n      = sel_q;
    line_n     = line_q;
    eop_n      = eop_q;
    strobe_n   = 1'b0;
    done_n     = 1'b0;
    under_n    = 1'b0;
    sync_start = 1'b0;
    j_bit      = 1'b0;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    go_eop     = 1'b0;
    ld         = '0;
    ld_len     = '0;
    ones_base  = ones_q;

    accept = (st_q == IDLE) && bus.tx_start && !done_q;

    if (accept) begin
      st_n       = SYNC;
      sel_n      = bus.tx_pid_sel;
      has_data_n = bus.tx_has_data;
      last_n     = 1'b0;
      eop_cnt_n  = '0;
      timer_n    = '0;
      strobe_n   = 1'b1;
      sync_start = 1'b1;
      ones_base  = '0;
      do_load    = 1'b1;
      ld         = place_byte(SYNC_BYTE);
      ld_len     = LW'(8);
    end else if (st_q != IDLE) begin
      if (timer_q != T_LAST) begin
        timer_n = timer_q + 1'b1;
      end else begin
        timer_n  = '0;
        strobe_n = 1'b1;
        if (st_q == EOP) begin
          if (eop_cnt_q < EOP_SE0_BITS) begin
            eop_cnt_n = eop_cnt_q + 2'd1;
            eop_n     = 1'b1;
            line_n    = 1'b0;
          end else if (eop_cnt_q == EOP_SE0_BITS) begin
            eop_cnt_n = eop_cnt_q + 2'd1;
            eop_n     = 1'b0;
            line_n    = 1'b1;
            j_bit     = 1'b1;
          end else begin
            st_n      = IDLE;
            done_n    = 1'b1;
            strobe_n  = 1'b0;
            eop_cnt_n = '0;
          end
        end else if (ones_q == STUFF_LIMIT) begin
          // Stuff bit: shift register and bit count hold for this bit time.
          line_n = 1'b0;
          ones_n = '0;
        end else if (left_q != '0) begin
          do_shift = 1'b1;
        end else begin
          case (st_q)
            SYNC: begin
              st_n    = PID;
              do_load = 1'b1;
              ld      = place_byte(pid_byte(sel_q));
              ld_len  = LW'(8);
            end
            PID, DATA: begin
              if ((st_q == PID && !has_data_q) || (st_q == DATA && last_q)) begin
                go_eop = 1'b1;
              end else if (bus.in_valid && ready_q) begin
                st_n    = DATA;
                do_load = 1'b1;
                ld      = bus.in_data;
                ld_len  = LW'(DATA_W);
                last_n  = bus.in_last;
              end else begin
                under_n = 1'b1;
                go_eop  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end

    if (go_eop) begin
      st_n      = EOP;
      eop_n     = 1'b1;
      line_n    = 1'b0;
      eop_cnt_n = 2'd1;
    end

    if (do_load) begin
      line_n = first_bit(ld);
      sh_n   = shift_one(ld);
      left_n = ld_len - 1'b1;
    end else if (do_shift) begin
      line_n = first_bit(sh_q);
      sh_n   = shift_one(sh_q);
      left_n = left_q - 1'b1;
    end

    if (do_load || do_shift)
      ones_n = line_n ? ones_base + 3'd1 : '0;

    // Ready covers the last clock of the field's final bit, or of the stuff bit after it.
    ready_n = ((st_n == PID && has_data_n) || (st_n == DATA && !last_n)) &&
              (left_n == '0) && (ones_n != STUFF_LIMIT) && (timer_n == T_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      timer_q    <= '0;
      sh_q       <= '0;
      left_q     <= '0;
      ones_q     <= '0;
      eop_cnt_q  <= '0;
      last_q     <= 1'b0;
      has_data_q <= 1'b0;
      sel_q      <= '0;
      line_q     <= 1'b1;
      eop_q      <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      under_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      st_q       <= st_n;
      timer_q    <= timer_n;
      sh_q       <= sh_n;
      left_q     <= left_n;
      ones_q     <= ones_n;
      eop_cnt_q  <= eop_cnt_n;
      last_q     <= last_n;
      has_data_q <= has_data_n;
      sel_q      <= sel_n;
      line_q     <= line_n;
      eop_q      <= eop_n;
      strobe_q   <= strobe_n;
      busy_q     <= (st_n != IDLE);
      done_q     <= done_n;
      under_q    <= under_n;
      ready_q    <= ready_n;
    end
  end

`ifdef USB_TX_NRZI_EN
  usb_nrzi_enc u_nrzi (
    .clk        (clk),
    .rst        (rst),
    .strobe     (strobe_n),
    .sync_start (sync_start),
    .se0        (eop_n),
    .j_force    (j_bit),
    .data_bit   (line_n),
    .line       (serial_out)
  );
`else
  logic nrzi_unused;
  always_comb begin
    nrzi_unused = sync_start ^ j_bit;
    serial_out  = line_q;
  end
`endif

  always_comb begin
    bit_strobe   = strobe_q;
    eop          = eop_q;
    busy         = busy_q;
    done         = done_q;
    underrun     = under_q;
    bus.in_ready = ready_q;
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: one instance at 1 clock/bit and one
// at 4 clocks/bit; line symbols are captured on bit_strobe and compared.
module tb_usb_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel;
  logic       start;
  logic [2:0] pid_sel;
  logic       has_data;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  usb_tx_serializer_if #(.DATA_W(8)) bus1 ();
  usb_tx_serializer_if #(.DATA_W(8)) bus4 ();

  assign bus1.tx_start    = start & ~sel;
  assign bus4.tx_start    = start & sel;
  assign bus1.tx_pid_sel  = pid_sel;
  assign bus4.tx_pid_sel  = pid_sel;
  assign bus1.tx_has_data = has_data;
  assign bus4.tx_has_data = has_data;
  assign bus1.in_data     = in_data;
  assign bus4.in_data     = in_data;
  assign bus1.in_valid    = in_valid & ~sel;
  assign bus4.in_valid    = in_valid & sel;
  assign bus1.in_last     = in_last;
  assign bus4.in_last     = in_last;

  logic ser1, stb1, eop1, busy1, done1, und1;
  logic ser4, stb4, eop4, busy4, done4, und4;

  usb_tx_serializer #(.DATA_W(8), .BIT_PERIOD(1), .SHIFT_MSB(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .serial_out(ser1), .bit_strobe(stb1),
    .eop(eop1), .busy(busy1), .done(done1), .underrun(und1)
  );

  usb_tx_serializer #(.DATA_W(8), .BIT_PERIOD(4), .SHIFT_MSB(0)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .serial_out(ser4), .bit_strobe(stb4),
    .eop(eop4), .busy(busy4), .done(done4), .underrun(und4)
  );

  logic o_ser, o_stb, o_eop, o_busy, o_done, o_und, o_rdy;
  always_comb begin
    if (sel) {o_ser, o_stb, o_eop, o_busy, o_done, o_und, o_rdy} =
               {ser4, stb4, eop4, busy4, done4, und4, bus4.in_ready};
    else     {o_ser, o_stb, o_eop, o_busy, o_done, o_und, o_rdy} =
               {ser1, stb1, eop1, busy1, done1, und1, bus1.in_ready};
  end

  // Capture results of the last packet run.
  int          nsym, nready, rdy_at, nunder, und_at, nxfer, done_at;
  logic [63:0] gsyms;
  logic        b1, s1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Symbols: 0/1 line level, 2 = SE0. Raw string lists the stuffed bit stream.
  function automatic logic [63:0] exp_syms(input string raw);
    logic [63:0] v;
    logic        lvl;
    int          n;
    v   = '0;
    lvl = 1'b1;
    n   = raw.len();
    for (int i = 0; i < n; i++) begin
      logic b;
      b = (raw[i] == "1");
`ifdef USB_TX_NRZI_EN
      if (!b) lvl = ~lvl;
      b = lvl;
`endif
      v[2*i +: 2] = {1'b0, b};
    end
    v[2*n +: 2]     = 2'd2;
    v[2*n + 2 +: 2] = 2'd2;
    v[2*n + 4 +: 2] = 2'd1;
    return v;
  endfunction

  task automatic run_pkt(input logic [2:0] pid, input logic hd, input int nv,
                         input logic lastw, input logic [7:0] word,
                         input int max_cyc, input int poke_at);
    int   idx;
    logic pend;
    idx = 0; pend = 1'b0;
    nsym = 0; gsyms = '0; nready = 0; rdy_at = -1; nunder = 0; und_at = -1;
    nxfer = 0; done_at = -1; b1 = 1'b0; s1 = 1'b0;
    pid_sel  = pid;
    has_data = hd;
    in_data  = word;
    in_valid = (nv > 0);
    in_last  = lastw && (nv == 1);
    start    = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk);
      #1;
      start = (c == poke_at);
      if (pend) begin
        idx++;
        nxfer++;
        pend     = 1'b0;
        in_valid = (idx < nv);
        in_last  = lastw && (idx == nv - 1);
      end
      if (c == 1) begin
        b1 = o_busy;
        s1 = o_stb;
      end
      if (o_stb) begin
        if (nsym < 32) gsyms[2*nsym +: 2] = o_eop ? 2'd2 : {1'b0, o_ser};
        nsym++;
      end
      if (o_rdy) begin
        nready++;
        if (rdy_at < 0) rdy_at = c;
        if (in_valid) pend = 1'b1;
      end
      if (o_und) begin
        nunder++;
        und_at = c;
      end
      if (o_done) begin
        done_at = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int extra;
    sel = 1'b0; start = 1'b0; pid_sel = '0; has_data = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_serial", ser1, 1);
    check("rst_strobe", stb1, 0);
    check("rst_eop", eop1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_underrun", und1, 0);
    check("rst_ready", bus1.in_ready, 0);
    check("rst_serial_bp4", ser4, 1);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // ACK, no payload, 1 clock/bit
    sel = 1'b0;
    run_pkt(3'd2, 1'b0, 0, 1'b0, 8'h00, 40, 0);
    check("ack_busy_t1", b1, 1);
    check("ack_strobe_t1", s1, 1);
    check("ack_len", nsym, 19);
    check("ack_syms", gsyms, exp_syms("0000000101001011"));
    check("ack_done_at", done_at, 20);
    check("ack_ready", nready, 0);
    @(posedge clk); #1;
    check("ack_idle_j", o_ser, 1);
    check("ack_idle_busy", o_busy, 0);

    // DATA0 + 8'hFF (last): stuff bit after 6 ones spanning PID/payload
    run_pkt(3'd0, 1'b1, 1, 1'b1, 8'hFF, 60, 0);
    check("d0_len", nsym, 28);
    check("d0_syms", gsyms, exp_syms("0000000111000011111101111"));
    check("d0_ready_cnt", nready, 1);
    check("d0_ready_at", rdy_at, 16);
    check("d0_xfer", nxfer, 1);
    check("d0_underrun", nunder, 0);
    check("d0_done_at", done_at, 29);

    // DATA1 at 4 clocks/bit, second word missing -> underrun
    @(negedge clk);
    sel = 1'b1;
    run_pkt(3'd1, 1'b1, 1, 1'b0, 8'h00, 200, 0);
    check("ur_len", nsym, 27);
    check("ur_syms", gsyms, exp_syms("000000011101001000000000"));
    check("ur_ready_cnt", nready, 2);
    check("ur_ready_at", rdy_at, 64);
    check("ur_xfer", nxfer, 1);
    check("ur_underrun_cnt", nunder, 1);
    check("ur_underrun_at", und_at, 97);
    check("ur_done_at", done_at, 109);

    // tx_start while busy and in the done cycle are both ignored
    @(negedge clk);
    sel = 1'b0;
    run_pkt(3'd2, 1'b0, 0, 1'b0, 8'h00, 40, 5);
    check("ign_len", nsym, 19);
    check("ign_done_at", done_at, 20);
    start = 1'b1;
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (o_busy || o_stb) extra++;
    end
    check("ign_no_restart", extra, 0);

    // Reset in the middle of the payload
    @(negedge clk);
    run_pkt(3'd0, 1'b1, 1, 1'b1, 8'hFF, 20, 0);
    check("mid_busy_pre", o_busy, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_serial", o_ser, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_eop", o_eop, 0);
    @(posedge clk); #1;
    check("mid_rst_serial_clk", o_ser, 1);
    check("mid_rst_ready_clk", o_rdy, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    run_pkt(3'd2, 1'b0, 0, 1'b0, 8'h00, 40, 0);
    check("post_rst_syms", gsyms, exp_syms("0000000101001011"));
    check("post_rst_done_at", done_at, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
